// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the tekito writeback stage: destination encodings,
// default datapath width and reset values.
package reg_writeback_pkg;

  // Destination select taken from instruction bits M[7:6]
  typedef enum logic [1:0] {
    DST_A    = 2'b00,
    DST_B    = 2'b01,
    DST_PORT = 2'b10,
    DST_PC   = 2'b11
  } dst_e;

  localparam int WIDTH_DEF = 4;

  // Reset values: PC start address, and the value that data registers
  // (A, B, PORT_DATA) and single-bit flags (C, PORT_VLD) clear to.
  localparam int   RESET_PC_DEF = 0;
  localparam int   RESET_REG    = 0;
  localparam logic RESET_FLAG   = 1'b0;

endpackage

// File: rtl/reg_writeback_if.sv
// Output-port handshake bundle.
// Handshake: the producer (master) raises PORT_VLD while PORT_DATA holds a
// value that has not yet been taken. The consumer (slave) raises PORT_ACK to
// take it. A transfer happens on every rising edge where PORT_VLD and PORT_ACK
// are both 1. PORT_ACK while PORT_VLD=0 has no effect.
interface reg_writeback_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] PORT_DATA;
  logic             PORT_VLD;
  logic             PORT_ACK;

  modport master (
    output PORT_DATA,
    output PORT_VLD,
    input  PORT_ACK
  );

  modport slave (
    input  PORT_DATA,
    input  PORT_VLD,
    output PORT_ACK
  );
endinterface

// File: rtl/reg_writeback_out_port_reg.sv
// Output-port latch. Holds PORT_DATA/PORT_VLD and produces the stall term.
// A new write is blocked only while an earlier value is still unacknowledged.
// When the earlier value is taken on the same edge, the new value replaces it
// immediately, so no bubble appears on the port.
module out_port_reg
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] res,
  input  logic             port_ack,
  output logic [WIDTH-1:0] port_data,
  output logic             port_vld,
  output logic             stall
);

  logic [WIDTH-1:0] port_data_q, port_data_d;
  logic             port_vld_q, port_vld_d;
  logic             wr_retire;

  // Stall and next-state for the port latch; stall uses only registered
  // valid and current control inputs, never the data.
  always_comb begin
    stall       = wr_req & port_vld_q & ~port_ack;
    wr_retire   = wr_req & ~stall;
    port_data_d = port_data_q;
    port_vld_d  = port_vld_q;
    if (wr_retire) begin
      port_data_d = res;
      port_vld_d  = 1'b1;
    end else if (port_ack) begin
      port_vld_d  = 1'b0;
    end
  end

  // Port latch registers; reset discards any pending value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port_data_q <= WIDTH'(RESET_REG);
      port_vld_q  <= RESET_FLAG;
    end else begin
      port_data_q <= port_data_d;
      port_vld_q  <= port_vld_d;
    end
  end

  assign port_data = port_data_q;
  assign port_vld  = port_vld_q;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage behind the 4-bit adder: routes the adder result to A, B,
// the output port or the PC, keeps the carry flag and advances the PC.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [1:0]         DST,
  input  logic               COND,
  input  logic [WIDTH-1:0]   RES,
  input  logic               FLG,
  reg_writeback_if.master    port_if,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   PC,
  output logic               C,
  output logic               STALL
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             c_q, c_d;
  logic             port_wr_req;
  logic             port_stall;
  logic             retire;
  logic             jump_taken;

  // Port latch and the only source of stall.
  out_port_reg #(.WIDTH(WIDTH)) u_out_port_reg (
    .clk       (CLK),
    .rst_n     (RST_N),
    .wr_req    (port_wr_req),
    .res       (RES),
    .port_ack  (port_if.PORT_ACK),
    .port_data (port_if.PORT_DATA),
    .port_vld  (port_if.PORT_VLD),
    .stall     (port_stall)
  );

  // Next-state for A/B/C/PC; everything holds unless the instruction retires.
  always_comb begin
    port_wr_req = EN & (dst_e'(DST) == DST_PORT);
    retire      = EN & ~port_stall;
    // Jump-if-no-carry looks at the carry from the previous instruction.
    jump_taken  = ~COND | ~c_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    pc_d        = pc_q;
    if (retire) begin
      c_d  = FLG;
      pc_d = pc_q + WIDTH'(1);
      case (dst_e'(DST))
        DST_A:    a_d = RES;
        DST_B:    b_d = RES;
        DST_PORT: ;
        DST_PC:   if (jump_taken) pc_d = RES;
        default:  ;
      endcase
    end
  end

  // Architectural registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_q  <= WIDTH'(RESET_REG);
      b_q  <= WIDTH'(RESET_REG);
      c_q  <= RESET_FLAG;
      pc_q <= WIDTH'(RESET_PC);
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      pc_q <= pc_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign C     = c_q;
  assign PC    = pc_q;
  assign STALL = port_stall;

endmodule
